// File: rtl/rv32_pkg.sv
// Shared RV32 constants and the fetch-entry record used by the fetch front end.
package rv32_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/grant and in-order response bus.
interface if_fetch_unit_if;
  import rv32_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry FIFO of {pc, instr}; a simultaneous push and pop is accepted while full.
module fetch_fifo
  import rv32_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  fetch_entry_t     i_data,
  output fetch_entry_t     o_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// RV32 fetch front end: PC, credit-limited imem requests, prefetch FIFO and IF/ID register.
module if_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stall,
  input  logic              i_redirect,
  input  logic [XLEN-1:0]   i_redirect_pc,
  if_fetch_unit_if.master   imem,
  output logic [XLEN-1:0]   o_if_pc,
  output logic [XLEN-1:0]   o_if_instruction,
  output logic [XLEN-1:0]   o_if_pc_plus4,
  output logic              o_if_valid
);

  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned DISC_W = CNT_W + 2;
  localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(DEPTH);
  localparam logic [XLEN-1:0] RESET_FETCH_PC = {RESET_PC[XLEN-1:2], 2'b00};

  logic [XLEN-1:0]   r_fetch_pc;
  logic [CNT_W-1:0]  r_outstanding;
  logic [DISC_W-1:0] r_discard;
  logic [XLEN-1:0]   r_if_pc;
  logic [XLEN-1:0]   r_if_instr;
  logic [XLEN-1:0]   r_if_plus4;
  logic              r_if_valid;

  logic [XLEN-1:0]   w_fetch_pc_d;
  logic [CNT_W-1:0]  w_outstanding_d;
  logic [DISC_W-1:0] w_discard_d;
  logic [XLEN-1:0]   w_if_pc_d;
  logic [XLEN-1:0]   w_if_instr_d;
  logic [XLEN-1:0]   w_if_plus4_d;
  logic              w_if_valid_d;

  fetch_entry_t      w_tag_in;
  fetch_entry_t      w_tag_head;
  logic [CNT_W-1:0]  w_tag_count;
  logic              w_tag_empty;
  logic              w_tag_full;
  fetch_entry_t      w_rsp_entry;
  fetch_entry_t      w_fifo_head;
  fetch_entry_t      w_load;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_fifo_empty;
  logic              w_fifo_full;

  logic w_req_fire;
  logic w_pending;
  logic w_rsp_accept;
  logic w_rsp_drop;
  logic w_if_advance;
  logic w_bypass;
  logic w_fifo_push;
  logic w_fifo_pop;
  logic w_unused;

  // Credits cover both in-flight requests and buffered words, so the FIFO cannot overflow.
  assign imem.imem_req  = i_rst_n && !i_redirect &&
                          (({1'b0, r_outstanding} + {1'b0, w_fifo_count}) < CREDITS);
  assign imem.imem_addr = r_fetch_pc;

  assign w_req_fire   = imem.imem_req && imem.imem_gnt;
  assign w_pending    = (r_discard != '0) || (r_outstanding != '0);
  assign w_rsp_drop   = imem.imem_rvalid && (r_discard != '0);
  assign w_rsp_accept = imem.imem_rvalid && !i_redirect && (r_discard == '0) &&
                        (r_outstanding != '0);

  assign w_tag_in    = '{pc: r_fetch_pc, instr: '0};
  assign w_rsp_entry = '{pc: w_tag_head.pc, instr: imem.imem_rdata};

  // An empty FIFO lets the arriving word go straight into IF/ID, saving a cycle.
  assign w_if_advance = !i_redirect && !i_stall;
  assign w_bypass     = w_if_advance && w_fifo_empty && w_rsp_accept;
  assign w_fifo_push  = w_rsp_accept && !w_bypass;
  assign w_fifo_pop   = w_if_advance && !w_fifo_empty;
  assign w_load       = w_fifo_empty ? w_rsp_entry : w_fifo_head;

  assign w_unused = ^{i_redirect_pc[1:0], w_tag_head.instr, w_tag_count, w_tag_empty,
                      w_tag_full, w_fifo_full};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_tag_queue (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_req_fire),
    .i_pop   (w_rsp_accept),
    .i_flush (i_redirect),
    .i_data  (w_tag_in),
    .o_data  (w_tag_head),
    .o_count (w_tag_count),
    .o_empty (w_tag_empty),
    .o_full  (w_tag_full)
  );

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_prefetch (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_fifo_push),
    .i_pop   (w_fifo_pop),
    .i_flush (i_redirect),
    .i_data  (w_rsp_entry),
    .o_data  (w_fifo_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  always_comb begin
    w_fetch_pc_d    = r_fetch_pc;
    w_outstanding_d = r_outstanding;
    w_discard_d     = r_discard;
    if (i_redirect) begin
      w_fetch_pc_d    = {i_redirect_pc[XLEN-1:2], 2'b00};
      w_outstanding_d = '0;
      // Every live or already-doomed response must be dropped, less one arriving right now.
      w_discard_d     = r_discard + DISC_W'(r_outstanding) -
                        DISC_W'(imem.imem_rvalid && w_pending);
    end else begin
      if (w_req_fire) w_fetch_pc_d = r_fetch_pc + 32'd4;
      w_outstanding_d = r_outstanding + CNT_W'(w_req_fire) - CNT_W'(w_rsp_accept);
      w_discard_d     = r_discard - DISC_W'(w_rsp_drop);
    end
  end

  always_comb begin
    w_if_pc_d    = r_if_pc;
    w_if_instr_d = r_if_instr;
    w_if_plus4_d = r_if_plus4;
    w_if_valid_d = r_if_valid;
    if (i_redirect) begin
      w_if_instr_d = NOP_INSTR;
      w_if_valid_d = 1'b0;
    end else if (!i_stall) begin
      if (!w_fifo_empty || w_rsp_accept) begin
        w_if_pc_d    = w_load.pc;
        w_if_instr_d = w_load.instr;
        w_if_plus4_d = w_load.pc + 32'd4;
        w_if_valid_d = 1'b1;
      end else begin
        w_if_instr_d = NOP_INSTR;
        w_if_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_pc    <= RESET_FETCH_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_if_pc       <= RESET_PC;
      r_if_instr    <= NOP_INSTR;
      r_if_plus4    <= RESET_PC + 32'd4;
      r_if_valid    <= 1'b0;
    end else begin
      r_fetch_pc    <= w_fetch_pc_d;
      r_outstanding <= w_outstanding_d;
      r_discard     <= w_discard_d;
      r_if_pc       <= w_if_pc_d;
      r_if_instr    <= w_if_instr_d;
      r_if_plus4    <= w_if_plus4_d;
      r_if_valid    <= w_if_valid_d;
    end
  end

  assign o_if_pc          = r_if_pc;
  assign o_if_instruction = r_if_instr;
  assign o_if_pc_plus4    = r_if_plus4;
  assign o_if_valid       = r_if_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: latency-configurable imem model and an in-order IF/ID scoreboard.
module tb_if_fetch_unit;
  import rv32_pkg::*;

  localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] if_plus4;
  logic        if_valid;

  if_fetch_unit_if imem_bus ();

  if_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_stall          (stall),
    .i_redirect       (redirect),
    .i_redirect_pc    (redirect_pc),
    .imem             (imem_bus),
    .o_if_pc          (if_pc),
    .o_if_instruction (if_instr),
    .o_if_pc_plus4    (if_plus4),
    .o_if_valid       (if_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Instruction memory: in-order, fixed latency, data = addr ^ XOR_KEY.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t mq[$];
  int    lat = 1;
  int    cyc = 0;

  initial begin
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        mq.delete();
      end else begin
        if (imem_bus.imem_rvalid && mq.size() > 0) void'(mq.pop_front());
        if (imem_bus.imem_req && imem_bus.imem_gnt)
          mq.push_back('{addr: imem_bus.imem_addr, due: cyc + lat});
      end
      @(posedge clk);
      #1;
      if (rst_n && mq.size() > 0 && mq[0].due <= cyc + 1) begin
        imem_bus.imem_rvalid = 1'b1;
        imem_bus.imem_rdata  = mq[0].addr ^ XOR_KEY;
      end else begin
        imem_bus.imem_rvalid = 1'b0;
        imem_bus.imem_rdata  = 32'hDEAD_BEEF;
      end
    end
  end

  // Scoreboard: expected PCs in program order, popped on each newly loaded valid instruction.
  logic [31:0] exp_q[$];
  bit          sb_on = 1'b0;
  bit          prev_load = 1'b0;

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (sb_on && prev_load && if_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check32("sb_if_pc", if_pc, e);
        check32("sb_if_instruction", if_instr, e ^ XOR_KEY);
        check32("sb_if_pc_plus4", if_plus4, e + 32'd4);
      end
      prev_load = rst_n && !stall && !redirect;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(first + 32'(4 * i));
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      sample();
      k++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: %0d instructions still pending after %0d cycles, expected 0",
               name, exp_q.size(), budget);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check32({tag, "_if_pc"}, if_pc, 32'h0000_0000);
    check32({tag, "_if_pc_plus4"}, if_plus4, 32'h0000_0004);
    check32({tag, "_if_instruction"}, if_instr, NOP_INSTR);
    check32({tag, "_if_valid"}, 32'(if_valid), 32'd0);
    check32({tag, "_imem_req"}, 32'(imem_bus.imem_req), 32'd0);
  endtask

  typedef struct {
    logic [31:0] target;
    int          mem_lat;
    int          n;
    bit          with_stall;
    logic [31:0] exp_first;
    logic [31:0] exp_second;
  } rd_vec_t;

  rd_vec_t     vecs[4];
  logic [31:0] held;
  int          want;
  int          k;

  initial begin
    vecs[0] = '{32'h0000_0103, 3, 4, 1'b0, 32'h0000_0100, 32'h0000_0104};
    vecs[1] = '{32'h0000_0200, 1, 5, 1'b1, 32'h0000_0200, 32'h0000_0204};
    vecs[2] = '{32'hFFFF_FFFC, 1, 3, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[3] = '{32'h0000_1002, 2, 4, 1'b1, 32'h0000_1000, 32'h0000_1004};

    imem_bus.imem_gnt = 1'b1;

    // Reset values, then back-to-back fetch from RESET_PC with a 1-cycle memory.
    repeat (3) @(negedge clk);
    #1;
    check_reset_state("reset");
    push_seq(32'h0, 24);
    sb_on = 1'b1;
    step();
    rst_n = 1'b1;
    sample();
    check32("c0_imem_req", 32'(imem_bus.imem_req), 32'd1);
    check32("c0_imem_addr", imem_bus.imem_addr, 32'h0);
    step();
    sample();
    check32("c1_if_valid", 32'(if_valid), 32'd0);
    step();
    sample();
    check32("c2_if_valid", 32'(if_valid), 32'd1);
    check32("c2_if_pc", if_pc, 32'h0);
    repeat (7) begin
      step();
      sample();
    end
    check32("throughput_remaining", 32'(exp_q.size()), 32'd16);

    // Three-cycle stall: outputs frozen, credits exhausted, order preserved.
    step();
    stall = 1'b1;
    sample();
    held = if_pc;
    step();
    sample();
    check32("stall2_if_pc", if_pc, held);
    check32("stall2_imem_req", 32'(imem_bus.imem_req), 32'd0);
    step();
    sample();
    check32("stall3_if_pc", if_pc, held);
    check32("stall3_if_valid", 32'(if_valid), 32'd1);
    check32("stall3_imem_req", 32'(imem_bus.imem_req), 32'd0);
    step();
    stall = 1'b0;
    sample();
    check32("release_if_pc", if_pc, held);
    wait_drain("stall_resume", 40);
    sb_on = 1'b0;

    // Redirect table: stale responses dropped, bubble, restart at the aligned target.
    for (int v = 0; v < 4; v++) begin
      step();
      lat  = vecs[v].mem_lat;
      want = (vecs[v].mem_lat > 1) ? 2 : 1;
      k    = 0;
      sample();
      while (mq.size() != want && k < 20) begin
        step();
        sample();
        k++;
      end
      check32("inflight_before_redirect", 32'(mq.size()), 32'(want));
      step();
      redirect    = 1'b1;
      redirect_pc = vecs[v].target;
      stall       = vecs[v].with_stall;
      exp_q.delete();
      push_seq(vecs[v].exp_first, vecs[v].n);
      sample();
      sb_on = 1'b1;
      check32("redirect_imem_req", 32'(imem_bus.imem_req), 32'd0);
      step();
      redirect = 1'b0;
      sample();
      check32("post_redirect_if_valid", 32'(if_valid), 32'd0);
      check32("post_redirect_if_instruction", if_instr, NOP_INSTR);
      check32("post_redirect_imem_addr", imem_bus.imem_addr, vecs[v].exp_first);
      step();
      stall = 1'b0;
      sample();
      if (vecs[v].with_stall) begin
        check32("stalled_bubble_if_valid", 32'(if_valid), 32'd0);
        check32("stalled_bubble_if_instruction", if_instr, NOP_INSTR);
      end
      check32("second_imem_addr", imem_bus.imem_addr, vecs[v].exp_second);
      wait_drain("redirect_seq", 40);
      sb_on = 1'b0;
    end

    // Grant withheld for 5 cycles: address stable, bubbles to ID, clean resume.
    step();
    lat         = 1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0300;
    exp_q.delete();
    push_seq(32'h0000_0300, 16);
    sample();
    sb_on = 1'b1;
    step();
    redirect = 1'b0;
    repeat (4) step();
    imem_bus.imem_gnt = 1'b0;
    sample();
    held = imem_bus.imem_addr;
    for (int g = 2; g <= 5; g++) begin
      step();
      sample();
      check32("gnt_low_imem_addr", imem_bus.imem_addr, held);
      check32("gnt_low_imem_req", 32'(imem_bus.imem_req), 32'd1);
      if (g >= 3) check32("gnt_low_if_valid", 32'(if_valid), 32'd0);
    end
    step();
    imem_bus.imem_gnt = 1'b1;
    wait_drain("gnt_resume", 40);
    sb_on = 1'b0;

    // Asynchronous reset in the middle of a cycle, then restart from RESET_PC.
    step();
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    exp_q.delete();
    push_seq(32'h0, 6);
    sb_on = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    sample();
    check32("rerun_imem_addr", imem_bus.imem_addr, 32'h0);
    wait_drain("reset_rerun", 30);
    sb_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch front end of the RV32IM pipeline: the producer of the IF/ID interface that the decode stage consumes. It owns the PC, issues word requests to instruction memory over a request/grant plus in-order response handshake, and buffers returned words in a small prefetch FIFO. It drives the IF/ID outputs (PC, instruction, PC+4), honours decode-stage stalls, and squashes wrong-path fetches on a taken branch or jump redirect from EX.

## Interface
- RESET_PC, 32'h0000_0000, PC of first fetch after reset
- DEPTH, 2, prefetch FIFO entries; also the cap on outstanding requests plus buffered words
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- STALL  in  1  hazard unit: hold IF/ID outputs
- REDIRECT  in  1  EX: branch taken or jump
- REDIRECT_PC  in  32  EX target; bits [1:0] ignored
- IMEM_REQ  out  1  fetch request valid
- IMEM_ADDR  out  32  word-aligned fetch address
- IMEM_GNT  in  1  request accepted this cycle
- IMEM_RVALID  in  1  response word valid, in request order
- IMEM_RDATA  in  32  response word
- IF_PC  out  32  PC of instruction presented to ID
- IF_INSTRUCTION  out  32  instruction to ID
- IF_PC_PLUS4  out  32  IF_PC + 4
- IF_VALID  out  1  IF/ID slot holds a real instruction

## Operation
- fetch_pc: next address to request. Request handshake completes when IMEM_REQ && IMEM_GNT; fetch_pc += 4 (mod 2^32, wraps silently).
- IMEM_REQ = 1 when outstanding + fifo_count < DEPTH and REDIRECT = 0; IMEM_ADDR = fetch_pc. IMEM_ADDR must stay stable while IMEM_REQ is high without a grant.
- Each request pushes its PC into a PC-tag queue; each accepted response pops it and pushes {pc, word} into the FIFO. The credit rule guarantees the FIFO never overflows.
- IF/ID register: when STALL = 0, loads the FIFO head (IF_VALID = 1) and pops it. If the FIFO is empty, it loads a bubble: IF_INSTRUCTION = 32'h0000_0013 (NOP), IF_VALID = 0, IF_PC unchanged.
- When STALL = 1, all IF_* outputs hold and there is no pop. Fetching continues until the credits are exhausted.
- REDIRECT (wins over STALL):
  - fetch_pc <= {REDIRECT_PC[31:2], 2'b00}.
  - FIFO and tag queue are flushed.
  - IF/ID register is loaded with a bubble.
  - discard count <= current outstanding count (including a request granted the same cycle, which is suppressed because IMEM_REQ = 0).
- While discard > 0, each IMEM_RVALID decrements discard and its word is dropped. A response arriving in the REDIRECT cycle is dropped.
- An IMEM_RVALID with outstanding = 0 and discard = 0 is ignored.
- RST asserted mid-transaction clears all counters. Instruction memory must also be reset; stale responses are then ignored by the rule above.

## Timing
- Reset values:
  - fetch_pc = RESET_PC.
  - IF_PC = RESET_PC, IF_PC_PLUS4 = RESET_PC + 4.
  - IF_INSTRUCTION = 32'h0000_0013, IF_VALID = 0.
  - IMEM_REQ = 0 during reset; 1 in the first cycle after deassertion.
- Latency with a 1-cycle memory:
  - grant in cycle n, RVALID in n+1 (FIFO write at the end of n+1).
  - word on IF_* from cycle n+2.
  - Steady state is one instruction per cycle with DEPTH = 2.
- Redirect in cycle n: IMEM_ADDR = target from n+1. The first target instruction appears on IF_* no earlier than n+3.
- Simultaneous FIFO push and pop while full: allowed, count unchanged.
- Outputs are registered. IMEM_REQ and IMEM_ADDR are combinational from registered state only, not from IMEM_GNT.

## Structure
- Shared package rv32_pkg: NOP_INSTR = 32'h0000_0013, XLEN = 32, default RESET_PC.
- Sub-module fetch_fifo: parameterised DEPTH-entry FIFO of {pc[31:0], instr[31:0]} with push, pop, flush, count, empty and full. It is reused for the PC-tag queue, with the data field unused.
- Top level contains the fetch_pc register, outstanding and discard counters, and the IF/ID register.

## Test plan
- Reset release, RESET_PC = 0, 1-cycle memory returning addr ^ 32'hA5A5_0000 -> IF_PC sequence 0, 4, 8, … one per cycle from cycle 2, with matching words and IF_VALID = 1.
- STALL held 3 cycles with 1-cycle memory -> IF_* frozen, IMEM_REQ drops after 2 grants, no instruction skipped or duplicated after release.
- REDIRECT to 32'h0000_0103 with 2 requests outstanding and a 3-cycle memory -> both stale words dropped, next IF_PC = 32'h100, bubble (NOP, IF_VALID = 0) in between.
- REDIRECT and STALL in the same cycle -> IF_INSTRUCTION = NOP, IF_VALID = 0, fetch restarts at the target.
- IMEM_GNT low for 5 cycles -> IMEM_ADDR stable, ID receives bubbles, sequence resumes correctly.
- fetch_pc at 32'hFFFF_FFFC -> next fetch address 32'h0000_0000; RST pulse mid-fetch -> all outputs return to reset values asynchronously.
